// File: rtl/blc_avg_divider_if.sv
// blc_avg_divider_if: request/result handshake bundle for the Avg-BLC divider
interface blc_avg_divider_if #(
  parameter int DW_N = 20,
  parameter int DW_D = 8,
  parameter int CH_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [DW_N-1:0] in_dividend;
  logic [DW_D-1:0] in_divisor;
  logic            in_round;
  logic [CH_W-1:0] in_ch;
  logic            out_valid;
  logic            out_ready;
  logic [DW_N-1:0] out_quot;
  logic [DW_D-1:0] out_rem;
  logic            out_dz;
  logic [CH_W-1:0] out_ch;
  modport master (
    output in_valid, in_dividend, in_divisor, in_round, in_ch, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dz, out_ch
  );
  modport slave (
    input  in_valid, in_dividend, in_divisor, in_round, in_ch, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dz, out_ch
  );
endinterface

// File: rtl/blc_avg_divider.sv
// blc_avg_divider: iterative restoring unsigned divider with optional round-to-nearest and divide-by-zero flag
module blc_avg_divider #(
  parameter int DW_N = 20,
  parameter int DW_D = 8,
  parameter int CH_W = 2
) (
  input logic clk,
  input logic rst,
  blc_avg_divider_if.slave bus
);
  localparam int CW = $clog2(DW_N);
  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
  state_t state, state_nx;
  logic [DW_N-1:0] dvd, q, oq;
  logic [DW_D-1:0] dvs, r, orem, sub;
  logic [DW_D:0] p;
  logic [CH_W-1:0] ch, och;
  logic [CW-1:0] cnt;
  logic rnd, dz, odz, ge, up;
  assign p   = {r, dvd[DW_N-1]};
  assign ge  = p >= {1'b0, dvs};
  assign sub = p[DW_D-1:0] - dvs;
  assign up  = rnd && ({r, 1'b0} >= {1'b0, dvs});
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_quot  = oq;
  assign bus.out_rem   = orem;
  assign bus.out_dz    = odz;
  assign bus.out_ch    = och;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Divide-by-zero passes through ROUND so its result lands one edge after accept
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = bus.in_divisor == '0 ? ROUND : CALC;
      CALC:    if (cnt == '0) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {dvd, dvs, rnd, ch, dz, q, r, cnt} <= '0;
      {oq, orem, odz, och} <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          dvd <= bus.in_dividend;
          dvs <= bus.in_divisor;
          rnd <= bus.in_round;
          ch  <= bus.in_ch;
          dz  <= bus.in_divisor == '0;
          q   <= '0;
          r   <= '0;
          cnt <= CW'(DW_N - 1);
        end
        CALC: begin
          r   <= ge ? sub : p[DW_D-1:0];
          q   <= {q[DW_N-2:0], ge};
          dvd <= dvd << 1;
          cnt <= cnt - 1'b1;
        end
        ROUND: begin
          oq   <= dz ? '1 : q + DW_N'(up);
          orem <= dz ? '0 : r;
          odz  <= dz;
          och  <= ch;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_blc_avg_divider.sv
// tb_blc_avg_divider: directed vector table, corner sequences and randomized checks against an arithmetic model
module tb_blc_avg_divider;
  localparam int DW_N = 20;
  localparam int DW_D = 8;
  localparam int CH_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  blc_avg_divider_if #(.DW_N(DW_N), .DW_D(DW_D), .CH_W(CH_W)) bus();
  blc_avg_divider #(.DW_N(DW_N), .DW_D(DW_D), .CH_W(CH_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    longint dvd;
    longint dvs;
    bit     rnd;
    int     ch;
    longint q;
    longint r;
    bit     dz;
  } vec_t;
  vec_t vecs[9];
  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  function automatic void ref_div(input longint dvd, input longint dvs, input bit rnd,
                                  output longint q, output longint r, output bit dz);
    if (dvs == 0) begin
      q = (64'd1 << DW_N) - 1;
      r = 0;
      dz = 1'b1;
    end else begin
      q = dvd / dvs;
      r = dvd % dvs;
      dz = 1'b0;
      if (rnd && 2 * r >= dvs) q = q + 1;
    end
  endfunction
  task automatic issue(input longint dvd, input longint dvs, input bit rnd, input int ch, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_dividend = DW_N'(dvd);
    bus.in_divisor = DW_D'(dvs);
    bus.in_round = rnd;
    bus.in_ch = CH_W'(ch);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic ack();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_ack", bus.in_ready, 1);
    check("out_valid_after_ack", bus.out_valid, 0);
  endtask
  task automatic run_check(input string tag, input longint dvd, input longint dvs, input bit rnd,
                           input int ch, input longint eq, input longint er, input bit edz);
    int lat;
    issue(dvd, dvs, rnd, ch, lat);
    check({tag, "_lat"}, lat, edz ? 1 : DW_N + 1);
    check({tag, "_quot"}, bus.out_quot, eq);
    check({tag, "_rem"}, bus.out_rem, er);
    check({tag, "_dz"}, bus.out_dz, edz);
    check({tag, "_ch"}, bus.out_ch, ch);
    ack();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    longint mq, mr, q0, r0;
    bit mdz;
    int lat;
    bus.in_valid = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor = '0;
    bus.in_round = 1'b0;
    bus.in_ch = '0;
    bus.out_ready = 1'b0;
    vecs[0] = '{100, 7, 0, 2, 14, 2, 0};
    vecs[1] = '{20, 8, 1, 1, 3, 4, 0};
    vecs[2] = '{20, 8, 0, 3, 2, 4, 0};
    vecs[3] = '{100, 7, 1, 0, 14, 2, 0};
    vecs[4] = '{1000, 0, 0, 1, 20'hFFFFF, 0, 1};
    vecs[5] = '{1000, 10, 0, 2, 100, 0, 0};
    vecs[6] = '{1048575, 1, 1, 3, 1048575, 0, 0};
    vecs[7] = '{5, 255, 0, 0, 0, 5, 0};
    vecs[8] = '{254, 255, 1, 1, 1, 254, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_quot", bus.out_quot, 0);
    check("rst_rem", bus.out_rem, 0);
    check("rst_dz", bus.out_dz, 0);
    check("rst_ch", bus.out_ch, 0);
    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].rnd, vecs[i].ch,
                vecs[i].q, vecs[i].r, vecs[i].dz);
    // Back-pressure: DONE must hold and ignore new requests
    issue(300, 9, 0, 3, lat);
    check("bp_lat", lat, DW_N + 1);
    q0 = bus.out_quot;
    r0 = bus.out_rem;
    check("bp_quot", q0, 33);
    check("bp_rem", r0, 3);
    bus.in_valid = 1'b1;
    bus.in_dividend = 20'd77;
    bus.in_divisor = 8'd0;
    bus.in_ch = 2'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_ready", bus.in_ready, 0);
      check("bp_hold_quot", bus.out_quot, q0);
      check("bp_hold_rem", bus.out_rem, r0);
      check("bp_hold_ch", bus.out_ch, 3);
    end
    bus.in_valid = 1'b0;
    ack();
    check("bp_quot_kept", bus.out_quot, q0);
    @(negedge clk);
    check("bp_no_second_accept", bus.in_ready, 1);
    // Reset in the middle of CALC discards the operation
    bus.in_valid = 1'b1;
    bus.in_dividend = 20'd100;
    bus.in_divisor = 8'd7;
    bus.in_round = 1'b0;
    bus.in_ch = 2'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", bus.in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_quot", bus.out_quot, 0);
    check("mid_rst_rem", bus.out_rem, 0);
    check("mid_rst_dz", bus.out_dz, 0);
    check("mid_rst_ch", bus.out_ch, 0);
    run_check("post_rst", 100, 7, 0, 2, 14, 2, 0);
    for (int n = 0; n < 120; n++) begin
      longint dvd, dvs;
      bit rnd;
      int sel, ch;
      sel = $urandom_range(0, 9);
      dvd = (n % 10 == 0) ? (64'd1 << DW_N) - 1 : longint'($urandom_range(0, (1 << DW_N) - 1));
      dvs = sel == 0 ? 0 : sel == 1 ? 1 : sel == 2 ? 255 : longint'($urandom_range(1, 255));
      rnd = 1'($urandom_range(0, 1));
      ch = $urandom_range(0, 3);
      ref_div(dvd, dvs, rnd, mq, mr, mdz);
      run_check($sformatf("rnd%0d", n), dvd, dvs, rnd, ch, mq, mr, mdz);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
